// File: rtl/sr_mon_pkg.sv
// Shared types for the sr_cpu run monitor: supervisor states, failure codes
// and the width rule for the match index outputs.
package sr_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PASS,
        FAIL
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_TIMEOUT = 2'd1,
        FC_HANG    = 2'd2
    } fail_code_t;

    // Index ports stay at least one bit wide even when only one entry exists.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/sr_run_monitor_stall.sv
// Fetch-address hang detector: counts consecutive cycles in which the CPU
// fetch address has not moved and flags a hang at the configured limit.
module sr_stall_detect #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [ADDR_W-1:0] addr,
    output logic              hang
);

    // A zero limit disables detection; LIM keeps the counter well formed.
    localparam int unsigned LIM   = (STALL_LIMIT == 0) ? 1 : STALL_LIMIT;
    localparam int unsigned CNT_W = (LIM > 1) ? $clog2(LIM) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIM - 1);

    logic [ADDR_W-1:0] prev_q;
    logic [CNT_W-1:0]  stall_q;
    logic              same;

    assign same = (addr == prev_q);
    assign hang = (STALL_LIMIT != 0) && enable && same && (stall_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q  <= '0;
            stall_q <= '0;
        end else if (clear) begin
            prev_q  <= addr;
            stall_q <= '0;
        end else if (enable) begin
            prev_q <= addr;
            if (!same) begin
                stall_q <= '0;
            end else if (stall_q != CNT_MAX) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_run_monitor.sv
// Run supervisor for sr_cpu: polls debug registers round-robin and decides
// PASS on a signature match, FAIL on cycle timeout or fetch-address hang.
module sr_run_monitor
    import sr_mon_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned NUM_SIG     = 2,
    parameter int unsigned NUM_REGS    = 1,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_SIG*DATA_W-1:0]   sig_values,
    input  logic [NUM_REGS*5-1:0]       reg_list,
    output logic [4:0]                  regAddr,
    input  logic [DATA_W-1:0]           regData,
    input  logic [ADDR_W-1:0]           imAddr,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [1:0]                  fail_code,
    output logic [idx_w(NUM_SIG)-1:0]   match_sig,
    output logic [idx_w(NUM_REGS)-1:0]  match_reg,
    output logic [31:0]                 cycle_count
);

    localparam int unsigned SIG_W = idx_w(NUM_SIG);
    localparam int unsigned REG_W = idx_w(NUM_REGS);
    localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT - 1);

    state_t            state_q;
    fail_code_t        fail_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [SIG_W-1:0]  match_sig_q;
    logic [REG_W-1:0]  match_reg_q;
    logic [31:0]       cycle_q;
    logic [REG_W-1:0]  ptr_q;
    logic [REG_W-1:0]  ptr_d;

    logic              in_run;
    logic              launch;
    logic              hit;
    logic [SIG_W-1:0]  hit_idx;
    logic              hang;

    assign in_run = (state_q == RUN);
    assign launch = start && !in_run;

    always_comb begin
        regAddr = '0;
        for (int unsigned j = 0; j < NUM_REGS; j++) begin
            if (ptr_q == REG_W'(j)) begin
                regAddr = reg_list[j*5 +: 5];
            end
        end
    end

    always_comb begin
        if (ptr_q == REG_W'(NUM_REGS - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    // Lowest matching slot wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned k = 0; k < NUM_SIG; k++) begin
            if (!hit && (regData == sig_values[k*DATA_W +: DATA_W])) begin
                hit     = 1'b1;
                hit_idx = SIG_W'(k);
            end
        end
    end

    sr_stall_detect #(
        .ADDR_W      (ADDR_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk    (clk),
        .rst    (rst),
        .clear  (launch),
        .enable (in_run),
        .addr   (imAddr),
        .hang   (hang)
    );

    // Decision cycles freeze cycle_q and ptr_q so the terminal state shows
    // the cycle and address on which the verdict was reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fail_q      <= FC_NONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            match_sig_q <= '0;
            match_reg_q <= '0;
            cycle_q     <= '0;
            ptr_q       <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hit) begin
                        state_q     <= PASS;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        pass_q      <= 1'b1;
                        match_sig_q <= hit_idx;
                        match_reg_q <= ptr_q;
                    end else if (hang) begin
                        state_q <= FAIL;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        fail_q  <= FC_HANG;
                    end else if (cycle_q == LAST_CYCLE) begin
                        state_q <= FAIL;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        fail_q  <= FC_TIMEOUT;
                    end else begin
                        cycle_q <= (cycle_q == '1) ? cycle_q : cycle_q + 32'd1;
                        ptr_q   <= ptr_d;
                    end
                end
                default: begin
                    if (start) begin
                        state_q     <= RUN;
                        fail_q      <= FC_NONE;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        match_sig_q <= '0;
                        match_reg_q <= '0;
                        cycle_q     <= '0;
                        ptr_q       <= '0;
                    end
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fail_q;
    assign match_sig   = match_sig_q;
    assign match_reg   = match_reg_q;
    assign cycle_count = cycle_q;

endmodule
